dtu: RTL

DTU -- requirements
Module: dtu

---
 rtl/dtu_pkg.sv | 21 ++
 rtl/dtu_fifo.sv | 63 ++++++
 rtl/dtu.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dtu_pkg.sv
// Shared types and line constants for the DTU 4x-oversampled nibble transmitter.
package dtu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GUARD
  } state_t;

  localparam logic [7:0] IDLE_WORD    = 8'hFF;
  localparam logic [7:0] PRE_WORD     = 8'h0F;
  localparam logic [3:0] UNDERRUN_NIB = 4'hF;

  // Expand one bit pair into eight samples; bp[1] is the older bit (b0).
  function automatic logic [7:0] line_word(input logic [1:0] bp);
    return {{4{bp[1]}}, {4{bp[0]}}};
  endfunction

endpackage

// File: rtl/dtu_fifo.sv
// Nibble FIFO for the DTU: wrap-bit pointers plus a registered occupancy count.
module dtu_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  output logic [3:0] pop_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [3:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  // Pointers match (wrap bit included) only when empty; full comes from occupancy.
  assign empty    = (wr_q == rd_q);
  assign full     = (cnt_q == PW'(DEPTH));
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + PW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    // NOTE: sequential state is assigned with <= so all flops update together.
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge c) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/dtu.sv
// DTU: frames buffered nibbles as preamble + 2-bit/clock payload + guard, 4x oversampled.
// Define DTU_PARITY_EN to append an even-parity clock after the payload.
module dtu
  import dtu_pkg::*;
#(
  parameter int NIB   = 12,
  parameter int GUARD = 4,
  parameter int DEPTH = 4
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic [3:0] i,
  input  logic       iv,
  output logic       ir,
  output logic [7:0] o,
  output logic       busy,
  output logic       urun
);

  localparam int PAY  = 2 * NIB;
  localparam int CMAX = (PAY > GUARD) ? PAY : GUARD;
  localparam int CW   = $clog2(CMAX) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lo_q, lo_d;
  logic          par_q, par_d;
  logic [7:0]    o_q, o_d;
  logic          busy_q, busy_d;
  logic          urun_q, urun_d;
  logic          rdy_q;

  logic          push, pop, empty, full;
  logic [3:0]    fifo_dout, nib;

  // ir is held low through reset and rises on the first edge after release.
  assign ir   = rdy_q && !full;
  assign push = iv && ir;
  assign o    = o_q;
  assign busy = busy_q;
  assign urun = urun_q;

  dtu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .c        (c),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(i),
    .pop      (pop),
    .pop_data (fifo_dout),
    .empty    (empty),
    .full     (full)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_PRE;
      end
      S_PRE: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == CW'(PAY - 1)) begin
          cnt_d = '0;
`ifdef DTU_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_GUARD;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PAR: begin
        state_d = S_GUARD;
        cnt_d   = '0;
      end
      S_GUARD: begin
        if (cnt_q == CW'(GUARD - 1)) begin
          cnt_d   = '0;
          state_d = empty ? S_IDLE : S_PRE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // An empty FIFO at a pop slot substitutes the underrun nibble; frame length is unchanged.
  assign nib = empty ? UNDERRUN_NIB : fifo_dout;

  always_comb begin
    pop    = 1'b0;
    o_d    = IDLE_WORD;
    busy_d = 1'b0;
    urun_d = 1'b0;
    lo_d   = lo_q;
    par_d  = par_q;
    unique case (state_q)
      S_PRE: begin
        o_d    = PRE_WORD;
        busy_d = 1'b1;
        par_d  = 1'b0;
      end
      S_DATA: begin
        busy_d = 1'b1;
        if (!cnt_q[0]) begin
          pop    = 1'b1;
          urun_d = empty;
          o_d    = line_word(nib[3:2]);
          lo_d   = nib[1:0];
          par_d  = par_q ^ (^nib);
        end else begin
          o_d = line_word(lo_q);
        end
      end
      S_PAR: begin
        busy_d = 1'b1;
        o_d    = line_word({par_q, ~par_q});
      end
      S_GUARD: begin
        busy_d = 1'b1;
      end
      default: begin
        o_d = IDLE_WORD;
      end
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      o_q    <= IDLE_WORD;
      busy_q <= 1'b0;
      urun_q <= 1'b0;
      lo_q   <= '0;
      par_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      o_q    <= o_d;
      busy_q <= busy_d;
      urun_q <= urun_d;
      lo_q   <= lo_d;
      par_q  <= par_d;
      rdy_q  <= 1'b1;
    end
  end

endmodule
